i2c_req_arbiter: RTL and testbench

Round-robin arbiter that shares one i2c_controller between NUM_REQ requesters (e.g. sensor poller, config loader, host bridge).
- Accepts one write request (address byte plus data byte) per requester and sequences the controller's start/address/data_in.
- Waits for controller completion and returns per-requester NACK status.
- Sits between requester logic and the i2c_controller instance; single owner of the controller's command inputs.

---
 rtl/i2c_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 32 +++
 rtl/i2c_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the i2c request arbiter.
// Used by i2c_req_arbiter (optional watchdog enabled by macro I2C_ARB_TIMEOUT_EN).
package i2c_arb_pkg;

    localparam int I2C_ADDR_W      = 8;
    localparam int I2C_DATA_W      = 8;
    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: returns the first set request bit found
// searching upward from last_grant+1, wrapping at N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    logic [IDX_W:0] cand;

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (req[cand[IDX_W-1:0]]) begin
                grant = cand[IDX_W-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog with controller abort.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_nack,
    output logic                          rsp_timeout,
    output logic                          cont_start,
    output logic [I2C_ADDR_W-1:0]         cont_address,
    output logic [I2C_DATA_W-1:0]         cont_data_in,
    output logic                          cont_abort,
    input  logic                          cont_busy,
    input  logic                          cont_done,
    input  logic                          cont_nack
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("i2c_req_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("i2c_req_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t         state;
    arb_state_t         state_next;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick_grant;
    logic               pick_any;
    logic               latch_grant;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic               rsp_nack_d;
    logic               rsp_timeout_d;
    logic               cont_start_d;
    logic               cont_abort_d;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT_DONE) begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT_DONE) &&
                         (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Outputs are computed one cycle ahead here and registered below, so every
    // controller/requester-facing signal comes straight from a flop.
    always_comb begin
        state_next    = state;
        latch_grant   = 1'b0;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_nack_d    = 1'b0;
        rsp_timeout_d = 1'b0;
        cont_start_d  = 1'b0;
        cont_abort_d  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && !cont_busy) begin
                    latch_grant  = 1'b1;
                    cont_start_d = 1'b1;
                    req_ready_d  = NUM_REQ'(1) << pick_grant;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A completion in the watchdog's final cycle still counts as done.
                if (cont_done) begin
                    rsp_valid_d = NUM_REQ'(1) << grant_q;
                    rsp_nack_d  = cont_nack;
                    state_next  = RESP;
                end else if (timeout_hit) begin
                    rsp_valid_d   = NUM_REQ'(1) << grant_q;
                    rsp_nack_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cont_abort_d  = 1'b1;
                    state_next    = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant_q      <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_nack     <= 1'b0;
            rsp_timeout  <= 1'b0;
            cont_start   <= 1'b0;
            cont_abort   <= 1'b0;
            cont_address <= '0;
            cont_data_in <= '0;
        end else begin
            state       <= state_next;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_nack    <= rsp_nack_d;
            rsp_timeout <= rsp_timeout_d;
            cont_start  <= cont_start_d;
            cont_abort  <= cont_abort_d;
            if (latch_grant) begin
                grant_q      <= pick_grant;
                cont_address <= req_addr[pick_grant*I2C_ADDR_W +: I2C_ADDR_W];
                cont_data_in <= req_data[pick_grant*I2C_DATA_W +: I2C_DATA_W];
            end
            if (state == RESP) begin
                last_grant <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: directed steps with a grant/response scoreboard.
// Define I2C_ARB_TIMEOUT_EN for both DUT and bench to exercise the watchdog steps.
module tb_i2c_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_addr;
    logic [NUM_REQ*8-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic                   rsp_nack;
    logic                   rsp_timeout;
    logic                   cont_start;
    logic [7:0]             cont_address;
    logic [7:0]             cont_data_in;
    logic                   cont_abort;
    logic                   cont_busy;
    logic                   cont_done;
    logic                   cont_nack;

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
    } grant_t;

    typedef struct {
        int         idx;
        logic       nack;
        logic       tmo;
        logic [7:0] addr;
    } rsp_t;

    grant_t     grant_q[$];
    rsp_t       rsp_q[$];
    grant_t     mg;
    rsp_t       mr;
    logic [7:0] addr_tab[NUM_REQ];
    logic [7:0] data_tab[NUM_REQ];
    int         checks     = 0;
    int         failures   = 0;
    int         starts     = 0;
    int         exp_starts = 0;

    i2c_req_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_nack     (rsp_nack),
        .rsp_timeout  (rsp_timeout),
        .cont_start   (cont_start),
        .cont_address (cont_address),
        .cont_data_in (cont_data_in),
        .cont_abort   (cont_abort),
        .cont_busy    (cont_busy),
        .cont_done    (cont_done),
        .cont_nack    (cont_nack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reportFail(input string tag, input logic [31:0] obs);
        checks++;
        failures++;
        $display("[TB] FAIL %s: observed=%0h expected=nothing", tag, obs);
    endtask

    function automatic logic [27:0] outVec();
        return {req_ready, rsp_valid, rsp_nack, rsp_timeout, cont_start,
                cont_address, cont_data_in, cont_abort};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic busy);
        req_valid = valid;
        cont_busy = busy;
    endtask

    task automatic expectGrant(input int idx);
        grant_t g;
        g.idx  = idx;
        g.addr = addr_tab[idx];
        g.data = data_tab[idx];
        grant_q.push_back(g);
        exp_starts++;
    endtask

    task automatic expectRsp(input int idx, input logic nack, input logic tmo);
        rsp_t r;
        r.idx  = idx;
        r.nack = nack;
        r.tmo  = tmo;
        r.addr = addr_tab[idx];
        rsp_q.push_back(r);
    endtask

    task automatic waitStart(output bit ok);
        int n = 0;
        while (cont_start !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = (cont_start === 1'b1);
        if (!ok) reportFail("wait_start_timeout", 32'(n));
    endtask

    // Plays the controller: wait for start, drop the cleared requests in the
    // first WAIT_DONE cycle, then pulse done after 'delay' more cycles.
    task automatic serveOne(input logic nack, input logic [NUM_REQ-1:0] clr, input int delay);
        bit ok;
        waitStart(ok);
        if (ok) begin
            @(posedge clk);
            #1;
            req_valid = req_valid & ~clr;
            tick(delay);
            cont_done = 1'b1;
            cont_nack = nack;
            tick(1);
            cont_done = 1'b0;
            cont_nack = 1'b0;
        end
    endtask

    task automatic waitDrained(input int budget);
        int n = 0;
        while ((grant_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (grant_q.size() != 0 || rsp_q.size() != 0) begin
            reportFail("drain_timeout", 32'(grant_q.size() + rsp_q.size()));
            grant_q.delete();
            rsp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        tick(3);
        checkOutput(tag, 32'(outVec()), 32'd0);
        rst = 1'b0;
        grant_q.delete();
        rsp_q.delete();
    endtask

    // Scoreboard monitor: every start and every response must match the head of its queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (cont_start === 1'b1) begin
                starts++;
                if (grant_q.size() == 0) begin
                    reportFail("unexpected_start", 32'(req_ready));
                end else begin
                    mg = grant_q.pop_front();
                    checkOutput("req_ready", 32'(req_ready), 32'(4'b0001 << mg.idx));
                    checkOutput("cont_address", 32'(cont_address), 32'(mg.addr));
                    checkOutput("cont_data_in", 32'(cont_data_in), 32'(mg.data));
                end
            end else if (req_ready !== '0) begin
                reportFail("ready_without_start", 32'(req_ready));
            end
            if (rsp_valid !== '0) begin
                if (rsp_q.size() == 0) begin
                    reportFail("unexpected_rsp", 32'(rsp_valid));
                end else begin
                    mr = rsp_q.pop_front();
                    checkOutput("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << mr.idx));
                    checkOutput("rsp_nack", 32'(rsp_nack), 32'(mr.nack));
                    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(mr.tmo));
                    checkOutput("cont_abort", 32'(cont_abort), 32'(mr.tmo));
                    checkOutput("addr_hold", 32'(cont_address), 32'(mr.addr));
                end
            end else if (cont_abort !== 1'b0) begin
                reportFail("abort_without_rsp", 32'(cont_abort));
            end
        end
    end

    initial begin
        addr_tab[0] = 8'hA9; data_tab[0] = 8'h4D;
        addr_tab[1] = 8'h72; data_tab[1] = 8'h22;
        addr_tab[2] = 8'h3C; data_tab[2] = 8'h11;
        addr_tab[3] = 8'h5E; data_tab[3] = 8'hCA;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*8 +: 8] = addr_tab[i];
            req_data[i*8 +: 8] = data_tab[i];
        end
        applyStimulus('0, 1'b0);
        cont_done = 1'b0;
        cont_nack = 1'b0;

        $display("[TB] reset state");
        doReset("reset_outputs");
        tick(1);

        $display("[TB] single request, start latency");
        expectGrant(0);
        expectRsp(0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        @(negedge clk);
        checkOutput("latency_idle", 32'(cont_start), 32'd0);
        @(negedge clk);
        checkOutput("latency_start", 32'(cont_start), 32'd1);
        serveOne(1'b0, 4'b0001, 3);
        waitDrained(20);

        $display("[TB] round robin after reset");
        doReset("reset_before_rr");
        tick(1);
        expectGrant(0); expectRsp(0, 1'b0, 1'b0);
        expectGrant(1); expectRsp(1, 1'b0, 1'b0);
        expectGrant(2); expectRsp(2, 1'b0, 1'b0);
        starts = 0;
        exp_starts = 3;
        applyStimulus(4'b1111, 1'b0);
        serveOne(1'b0, 4'b0000, 2);
        serveOne(1'b0, 4'b0000, 4);
        serveOne(1'b0, 4'b1111, 1);
        waitDrained(40);
        tick(3);
        checkOutput("rr_start_count", 32'(starts), 32'(exp_starts));

        $display("[TB] busy gating");
        applyStimulus(4'b0100, 1'b1);
        tick(20);
        checkOutput("busy_no_start", 32'(starts), 32'(exp_starts));
        expectGrant(2);
        expectRsp(2, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("busy_release_idle", 32'(cont_start), 32'd0);
        @(negedge clk);
        checkOutput("busy_release_start", 32'(cont_start), 32'd1);
        serveOne(1'b0, 4'b0100, 2);
        waitDrained(20);

        $display("[TB] withdrawn request");
        applyStimulus(4'b0010, 1'b1);
        tick(5);
        applyStimulus(4'b0000, 1'b1);
        tick(1);
        applyStimulus(4'b0000, 1'b0);
        tick(6);
        checkOutput("withdraw_no_start", 32'(starts), 32'(exp_starts));

        $display("[TB] nack from requester 3");
        expectGrant(3);
        expectRsp(3, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        serveOne(1'b1, 4'b1000, 5);
        waitDrained(20);

        $display("[TB] reset during WAIT_DONE");
        expectGrant(1);
        expectRsp(1, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        serveOne(1'b0, 4'b0010, 2);
        waitDrained(20);
        begin
            bit ok;
            expectGrant(2);
            applyStimulus(4'b0100, 1'b0);
            waitStart(ok);
            @(posedge clk);
            #1;
            req_valid = '0;
            tick(3);
            rst = 1'b1;
            tick(1);
            checkOutput("midrst_outputs", 32'(outVec()), 32'd0);
            rst = 1'b0;
            tick(5);
        end
        expectGrant(0);
        expectRsp(0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        serveOne(1'b0, 4'b1111, 1);
        waitDrained(20);

`ifdef I2C_ARB_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        begin
            bit ok;
            int n;
            expectGrant(0);
            expectRsp(0, 1'b1, 1'b1);
            applyStimulus(4'b0001, 1'b0);
            waitStart(ok);
            @(posedge clk);
            #1;
            req_valid = '0;
            n = 0;
            while (cont_abort !== 1'b1 && n < 3 * TMO) begin
                @(negedge clk);
                n++;
            end
            checkOutput("abort_cycle", 32'(n), 32'(TMO + 1));
            waitDrained(10);
        end

        $display("[TB] done in final watchdog cycle");
        expectGrant(0);
        expectRsp(0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        serveOne(1'b0, 4'b0001, TMO - 1);
        waitDrained(10);
`endif

        tick(5);
        checkOutput("final_start_count", 32'(starts), 32'(exp_starts));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
